// File: rtl/draw_once.sv
// Random single-card draw from an availability vector: LFSR picks a start
// candidate, linear probing skips cards that are not available.
module draw_once #(
   parameter int          DECK_SIZE = 106,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 interboard_rst,
   input  logic                 draw_one,
   input  logic [DECK_SIZE-1:0] available_card,
   output logic                 done,
   output logic                 ready,
   output logic [6:0]           drawn_card_idx
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic [6:0] DECK = 7'(DECK_SIZE);
   localparam logic [6:0] LAST = 7'(DECK_SIZE - 1);

   logic [1:0]  state, state_n;
   logic [15:0] lfsr;
   logic [6:0]  cand, cand_n;
   logic [6:0]  probe, probe_n;
   logic [6:0]  idx_n;
   logic        done_n;
   logic        soft_rst;
   logic [6:0]  raw_cand;
   logic [6:0]  mapped_cand;

   assign soft_rst = ~rst | interboard_rst;
   assign ready    = (state == S_IDLE) & ~soft_rst;

   // A single subtraction folds 7-bit values into the deck range (deck of at least 64 cards)
   assign raw_cand    = lfsr[6:0];
   assign mapped_cand = (raw_cand >= DECK) ? raw_cand - DECK : raw_cand;

   always_ff @(posedge clk) begin
      if (!rst)
         lfsr <= LFSR_SEED;
      else
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

      if (soft_rst) begin
         state          <= S_IDLE;
         done           <= 1'b0;
         drawn_card_idx <= '0;
         probe          <= '0;
         cand           <= '0;
      end else begin
         state          <= state_n;
         done           <= done_n;
         drawn_card_idx <= idx_n;
         probe          <= probe_n;
         cand           <= cand_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      probe_n = probe;
      idx_n   = drawn_card_idx;
      done_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (draw_one) begin
               cand_n  = mapped_cand;
               probe_n = '0;
               state_n = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (available_card[cand]) begin
               idx_n   = cand;
               done_n  = 1'b1;
               state_n = S_DONE;
            end else if (probe == LAST) begin
               // Every card probed without a hit: deck is empty
               state_n = S_IDLE;
            end else begin
               cand_n  = (cand == LAST) ? '0 : cand + 7'd1;
               probe_n = probe + 7'd1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_draw_once.sv
// Scoreboard bench for draw_once: an LFSR/probe model predicts each draw
// at accept time; results are compared when done pulses.
module tb_draw_once;

   localparam int          N    = 106;
   localparam logic [15:0] SEED = 16'hACE1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         interboard_rst = 1'b0;
   logic         draw_one = 1'b0;
   logic [N-1:0] available_card = '0;
   logic         done;
   logic         ready;
   logic [6:0]   drawn_card_idx;

   always #5 clk = ~clk;

   draw_once #(.DECK_SIZE(N), .LFSR_SEED(SEED)) dut (
      .clk            (clk),
      .rst            (rst),
      .interboard_rst (interboard_rst),
      .draw_one       (draw_one),
      .available_card (available_card),
      .done           (done),
      .ready          (ready),
      .drawn_card_idx (drawn_card_idx)
   );

   typedef struct {
      int unsigned edge_no;
      logic        hit;
      logic [6:0]  idx;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned ecnt = 0;
   int unsigned busy_until = 0;
   logic [15:0] m_lfsr = SEED;
   logic        lfsr_valid = 1'b0;
   int unsigned dones = 0;
   int unsigned last_done_edge = 0;
   int unsigned last_accept_edge = 0;
   logic [6:0]  last_idx = '0;
   logic [N-1:0] seen = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic fb;
      fb = v[16-16] ^ v[16-14] ^ v[16-13] ^ v[16-11];
      return {fb, v[15:1]};
   endfunction

   function automatic int map_cand(input logic [15:0] v);
      int c;
      c = int'(v[6:0]);
      if (c >= N) c = c - N;
      return c;
   endfunction

   // One clock edge: predict its effect, let it happen, then compare.
   task automatic tick();
      logic        in_reset;
      logic [15:0] nl;
      logic        exp_done;
      exp_t        e;
      int          c;
      int          hitk;
      in_reset = !rst || interboard_rst;
      if (in_reset) begin
         sb.delete();
         busy_until = ecnt + 1;
      end else if (draw_one && ecnt >= busy_until) begin
         c    = map_cand(m_lfsr);
         hitk = 0;
         for (int k = 1; k <= N; k++) begin
            if (available_card[c]) begin
               hitk = k;
               break;
            end
            c = (c == N - 1) ? 0 : c + 1;
         end
         last_accept_edge = ecnt + 1;
         if (hitk != 0) begin
            e.edge_no = ecnt + 1 + hitk; e.hit = 1'b1; e.idx = 7'(c);
            busy_until = ecnt + 2 + hitk;
         end else begin
            e.edge_no = ecnt + 1 + N; e.hit = 1'b0; e.idx = '0;
            busy_until = ecnt + 1 + N;
         end
         sb.push_back(e);
      end
      nl = !rst ? SEED : lfsr_next(m_lfsr);
      @(posedge clk);
      ecnt++;
      m_lfsr = nl;
      if (!rst) lfsr_valid = 1'b1;
      #1;
      if (lfsr_valid) chk("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
      chk("ready", 32'(ready), 32'(rst && !interboard_rst && ecnt >= busy_until));
      exp_done = (sb.size() > 0) && (sb[0].edge_no == ecnt) && sb[0].hit;
      chk("done", 32'(done), 32'(exp_done));
      if (exp_done) chk("idx", 32'(drawn_card_idx), 32'(sb[0].idx));
      if (sb.size() > 0 && sb[0].edge_no == ecnt) void'(sb.pop_front());
      if (done === 1'b1) begin
         dones++;
         last_done_edge = ecnt;
         last_idx = drawn_card_idx;
         chk("repeat", 32'(seen[drawn_card_idx]), 32'd0);
         seen[drawn_card_idx] = 1'b1;
         available_card[drawn_card_idx] = 1'b0;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && ecnt < busy_until; i++) tick();
   endtask

   task automatic draw();
      draw_one = 1'b1;
      tick();
      draw_one = 1'b0;
      wait_idle();
   endtask

   int unsigned d0;
   logic        found;

   initial begin
      // Reset hold
      tick();
      tick();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_idx", 32'(drawn_card_idx), 32'd0);
      rst = 1'b1;
      #1;
      chk("lfsr_seed", 32'(dut.lfsr), 32'(SEED));
      tick();
      chk("ready_release", 32'(ready), 32'd1);

      // Full deck, draw_one tied high, each drawn card cleared
      available_card = '1;
      seen = '0;
      dones = 0;
      draw_one = 1'b1;
      for (int i = 0; i < 30000 && dones < N; i++) tick();
      for (int i = 0; i < 300; i++) tick();
      chk("full_count", dones, N);
      chk("distinct", $countones(seen), N);
      draw_one = 1'b0;
      wait_idle();
      tick();

      // Single available card, then an empty deck
      seen = '0;
      available_card = '0;
      available_card[57] = 1'b1;
      d0 = dones;
      draw();
      chk("card57_idx", 32'(last_idx), 32'd57);
      chk("card57_count", dones - d0, 1);
      d0 = dones;
      draw();
      chk("empty_no_done", dones - d0, 0);
      tick();

      // Wrap-around: candidate 105, only card 0 available
      seen = '0;
      available_card = '0;
      available_card[0] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         if (map_cand(m_lfsr) == 105 && ecnt >= busy_until) found = 1'b1;
         else tick();
      end
      chk("wrap_setup", 32'(found), 32'd1);
      draw();
      chk("wrap_idx", 32'(last_idx), 32'd0);
      chk("wrap_latency", last_done_edge - last_accept_edge, 2);
      tick();

      // draw_one pulsed during SEARCH is ignored
      seen = '0;
      available_card = '0;
      available_card[3] = 1'b1;
      d0 = dones;
      draw_one = 1'b1;
      tick();
      draw_one = 1'b0;
      for (int i = 0; i < 400 && ecnt < busy_until; i++) begin
         draw_one = (ecnt + 2 < busy_until) ? i[0] : 1'b0;
         tick();
      end
      draw_one = 1'b0;
      tick();
      chk("one_done", dones - d0, 1);

      // interboard_rst mid-SEARCH aborts; LFSR keeps running
      available_card = '0;
      d0 = dones;
      draw_one = 1'b1;
      tick();
      draw_one = 1'b0;
      tick();
      tick();
      tick();
      interboard_rst = 1'b1;
      tick();
      chk("ibrst_done", 32'(done), 32'd0);
      chk("ibrst_ready", 32'(ready), 32'd0);
      interboard_rst = 1'b0;
      #1;
      chk("ibrst_release_ready", 32'(ready), 32'd1);
      chk("ibrst_no_done", dones - d0, 0);
      seen = '0;
      available_card = '1;
      draw();
      chk("post_ibrst_draw", dones - d0, 1);
      for (int i = 0; i < 5; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
